spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_rr_picker.sv | 28 ++
 rtl/spi_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    localparam int TIMEOUT_CYCLES_DEF = 4096;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin winner selection: first set req at or above ptr, else wrap to the lowest set req.
module spi_rr_picker
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               win_any
);

    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] pool;

    always_comb begin
        hi_req  = req & ({NUM_REQ{1'b1}} << ptr);
        pool    = (|hi_req) ? hi_req : req;
        win_oh  = pool & (~pool + 1'b1);
        win_any = |req;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_oh[i]) win_idx = IW'(i);
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional watchdog on the master handshake: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_CS         = 1,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int SW = idx_w(NUM_CS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
    input  logic [NUM_REQ*SW-1:0]         req_slave_id,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_tx_data,
    output logic [SW-1:0]                 m_slave_id,
    input  logic                          m_ready,
    input  logic [DATA_WIDTH-1:0]         m_rx_data,
    output logic                          err
);

    localparam int IW = idx_w(NUM_REQ);

    // Packed slices line up with the flat buses, requester i in lane i.
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] tx_lane;
    logic [NUM_REQ-1:0][SW-1:0]         sid_lane;
    assign tx_lane  = req_tx_data;
    assign sid_lane = req_slave_id;

    arb_state_e         state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               win_any;

    spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    assign ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            done       <= '0;
            rx_data    <= '0;
            m_start    <= 1'b0;
            m_tx_data  <= '0;
            m_slave_id <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            err        <= 1'b0;
`endif
        end else begin
            done    <= '0;
            m_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_any && m_ready) begin
                        gnt        <= win_oh;
                        owner      <= win_idx;
                        m_tx_data  <= tx_lane[win_idx];
                        m_slave_id <= sid_lane[win_idx];
                        m_start    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        err   <= 1'b1;
                        done  <= gnt;
                        gnt   <= '0;
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end else
`endif
                    if (!m_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    // A real completion wins over a watchdog hit on the same edge.
                    if (m_ready) begin
                        rx_data <= m_rx_data;
                        done    <= gnt;
                        gnt     <= '0;
                        ptr     <= ptr_nxt;
                        state   <= IDLE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err   <= 1'b1;
                        done  <= gnt;
                        gnt   <= '0;
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a behavioural SPI master (rx = tx ^ 8'h99).
module tb_spi_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int SW  = 1;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_tx_data;
    logic [NR*SW-1:0]  req_slave_id;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rx_data;
    logic              m_start;
    logic [DW-1:0]     m_tx_data;
    logic [SW-1:0]     m_slave_id;
    logic              m_ready;
    logic [DW-1:0]     m_rx_data;
    logic              err;

    always #5 clk = ~clk;

    spi_arbiter #(
        .NUM_REQ(NR), .NUM_CS(1), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_tx_data(req_tx_data),
        .req_slave_id(req_slave_id), .gnt(gnt), .done(done), .rx_data(rx_data),
        .m_start(m_start), .m_tx_data(m_tx_data), .m_slave_id(m_slave_id),
        .m_ready(m_ready), .m_rx_data(m_rx_data), .err(err)
    );

    typedef struct packed {
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
        logic [SW-1:0] sid;
    } exp_t;

    exp_t          gnt_q[$];
    exp_t          done_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_start = 0;
    int            n_done = 0;
    int            rem[NR];
    bit            busy = 1'b0;
    bit            mst_hang = 1'b0;
    logic [DW-1:0] last_rx = '0;
    logic [DW-1:0] mst_tx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural master: goes busy two cycles after m_start, finishes three later.
    initial begin
        m_ready   = 1'b1;
        m_rx_data = '0;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1 && !mst_hang) begin
                mst_tx = m_tx_data;
                repeat (2) @(negedge clk);
                m_ready = 1'b0;
                repeat (3) @(negedge clk);
                m_rx_data = mst_tx ^ 8'h99;
                m_ready   = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every start and completion, and plays the requesters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_start) begin
                chk("no_overlap", 32'(busy), 0);
                busy = 1'b1;
                n_start++;
                if (gnt_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    mon_e = gnt_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(mon_e.oh));
                    chk("m_tx_data", 32'(m_tx_data), 32'(mon_e.data));
                    chk("m_slave_id", 32'(m_slave_id), 32'(mon_e.sid));
                end
            end
            if (|done) begin
                busy = 1'b0;
                n_done++;
                chk("gnt_clr", 32'(gnt), 0);
`ifndef SPI_ARB_TIMEOUT_EN
                chk("err_tied0", 32'(err), 0);
`endif
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    mon_e = done_q.pop_front();
                    chk("done", 32'(done), 32'(mon_e.oh));
                    chk("rx_data", 32'(rx_data), 32'(mon_e.data));
                end
                for (int i = 0; i < NR; i++)
                    if (done[i]) begin
                        if (rem[i] > 0) rem[i]--;
                        if (rem[i] == 0) req[i] = 1'b0;
                    end
            end
        end
    end

    task automatic set_slice(input int i, input logic [DW-1:0] tx, input logic [SW-1:0] sid);
        req_tx_data[i*DW +: DW]  = tx;
        req_slave_id[i*SW +: SW] = sid;
    endtask

    task automatic expect_xfer(input int i);
        exp_t e;
        e.oh   = NR'(1) << i;
        e.data = req_tx_data[i*DW +: DW];
        e.sid  = req_slave_id[i*SW +: SW];
        gnt_q.push_back(e);
        e.data = e.data ^ 8'h99;
        e.sid  = '0;
        done_q.push_back(e);
        last_rx = e.data;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((gnt_q.size() != 0 || done_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", gnt_q.size() + done_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input logic lvl, input int budget);
        int k = 0;
        while (m_ready !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("m_ready_wait", 32'(m_ready), 32'(lvl));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap;
        rst_n = 1'b0;
        req = '0;
        req_tx_data = '0;
        req_slave_id = '0;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_m_tx_data", 32'(m_tx_data), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting: 0,1,2,3 then 0 again; requester 3 uses out-of-range slave id 1.
        for (int i = 0; i < NR; i++) set_slice(i, DW'(8'h10 + i * 8'h11), SW'(i == 3));
        for (int i = 0; i < NR; i++) expect_xfer(i);
        expect_xfer(0);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        req = 4'b1111;
        drain(300);
        chk("rr_start_cnt", n_start, 5);
        chk("rr_done_cnt", n_done, 5);

        // Single request, one-cycle grant latency.
        set_slice(1, 8'hA5, 1'b0);
        expect_xfer(1);
        rem[1] = 1;
        req = 4'b0010;
        @(negedge clk);
        chk("lat_m_start", 32'(m_start), 1);
        chk("lat_gnt", 32'(gnt), 32'(4'b0010));
        drain(100);
        chk("rx_held_3c", 32'(rx_data), 32'h3C);

        // Late request waits for the running frame.
        set_slice(0, 8'h5A, 1'b0);
        set_slice(2, 8'hE7, 1'b0);
        expect_xfer(0);
        expect_xfer(2);
        rem[0] = 1; rem[2] = 1;
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        drain(200);

        // Owner drops req in WAIT_DONE: frame still completes, no further grant.
        set_slice(3, 8'hC3, 1'b1);
        expect_xfer(3);
        rem[3] = 1;
        req[3] = 1'b1;
        @(negedge clk);
        wait_ready(1'b0, 50);
        req[3] = 1'b0;
        drain(100);
        snap = n_start;
        repeat (10) @(negedge clk);
        chk("no_extra_start", n_start, snap);

        // Reset in WAIT_DONE aborts without a done pulse.
        set_slice(1, 8'h42, 1'b0);
        expect_xfer(1);
        void'(done_q.pop_back());
        rem[1] = 1;
        req[1] = 1'b1;
        @(negedge clk);
        wait_ready(1'b0, 50);
        snap = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_m_start", 32'(m_start), 0);
        chk("abort_m_tx_data", 32'(m_tx_data), 0);
        chk("abort_rx_data", 32'(rx_data), 0);
        chk("abort_done", 32'(done), 0);
        req = '0;
        busy = 1'b0;
        last_rx = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b1, 50);
        repeat (2) @(negedge clk);
        chk("abort_no_done", n_done, snap);
        chk("abort_gnt_q", gnt_q.size(), 0);
        set_slice(2, 8'h77, 1'b0);
        expect_xfer(2);
        rem[2] = 1;
        req = 4'b0100;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'(4'b0100));
        drain(100);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            exp_t e;
            int k;
            mst_hang = 1'b1;
            set_slice(0, 8'h31, 1'b0);
            e.oh = 4'b0001; e.data = 8'h31; e.sid = '0;
            gnt_q.push_back(e);
            e.data = last_rx;
            done_q.push_back(e);
            rem[0] = 1;
            req[0] = 1'b1;
            k = 0;
            while (m_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            chk("tmo_start", 32'(m_start), 1);
            k = 0;
            while (err !== 1'b1 && k < TMO + 5) begin @(negedge clk); k++; end
            chk("tmo_err", 32'(err), 1);
            chk("tmo_done", 32'(done), 1);
            chk("tmo_cycles", 32'(k >= TMO && k <= TMO + 2), 1);
            @(negedge clk);
            chk("tmo_err_pulse", 32'(err), 0);
            mst_hang = 1'b0;
            drain(50);
        end
`else
        chk("err_idle", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
